// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default framing parameters.
// Used by both the transmitter and the receiver.
package uart_pkg;

   localparam int unsigned DefDataBits   = 8;
   localparam int unsigned DefOversample = 16;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } uart_state_e;

endpackage

// File: rtl/uart_tick_counter.sv
// Mod-OVERSAMPLE sample-clock counter; bit_done_o pulses on the last tick of each bit period.
// Held at zero while disabled so every frame starts on a fresh bit boundary.
module uart_tick_counter #(
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   output logic bit_done_o
);

   localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TW-1:0] LastTick = TW'(OVERSAMPLE - 1);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      bit_done_o = en_i && (cnt_q == LastTick);
      cnt_d      = '0;
      if (en_i && !bit_done_o) begin
         cnt_d = cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1 framing, LSB first, one-entry holding register for back-to-back frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = DefDataBits,
   parameter int unsigned OVERSAMPLE = DefOversample,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                 sampleclk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] TX_DATA,
   input  logic                 TX_EN,
   output logic                 TX_STATUS,
   output logic                 TX_BUSY,
   output logic                 UART_TX
);

   localparam int unsigned CntW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CntW-1:0] LastData = CntW'(DATA_BITS - 1);
   localparam logic [CntW-1:0] LastStop = CntW'(STOP_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic                 hold_full_q, hold_full_d;
   logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 bit_done;
   logic                 accept;
   logic                 load;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   uart_tick_counter #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_tick (
      .clk_i      (sampleclk),
      .rst_ni     (reset),
      .en_i       (state_q != StIdle),
      .bit_done_o (bit_done)
   );

   assign TX_STATUS = ~hold_full_q;
   assign TX_BUSY   = busy_q;
   assign UART_TX   = tx_q;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      bit_cnt_d   = bit_cnt_q;
      load        = 1'b0;
      accept      = TX_EN && !hold_full_q;
`ifdef UART_TX_PARITY_EN
      parity_d    = parity_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (hold_full_q) begin
               load    = 1'b1;
               state_d = StStart;
            end
         end
         StStart: begin
            if (bit_done) begin
               state_d   = StData;
               bit_cnt_d = '0;
            end
         end
         StData: begin
            if (bit_done) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LastData) begin
                  bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = StParity;
`else
                  state_d   = StStop;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + CntW'(1);
               end
            end
         end
         StParity: begin
            if (bit_done) begin
               state_d   = StStop;
               bit_cnt_d = '0;
            end
         end
         StStop: begin
            // bit_cnt doubles as the stop-period counter for two-stop-bit frames.
            if (bit_done) begin
               if (bit_cnt_q == LastStop) begin
                  bit_cnt_d = '0;
                  if (hold_full_q) begin
                     load    = 1'b1;
                     state_d = StStart;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + CntW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (load) begin
         shift_d     = hold_q;
         hold_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_d    = ^hold_q;
`endif
      end
      if (accept) begin
         hold_d      = TX_DATA;
         hold_full_d = 1'b1;
      end

      // Line and busy flag follow the current state one clock later, keeping both registered.
      busy_d = (state_q != StIdle);
      unique case (state_q)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
         StParity: tx_d = parity_q;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge sampleclk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         bit_cnt_q   <= '0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_q        <= tx_d;
         busy_q      <= busy_d;
`ifdef UART_TX_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: stimulus queues expected frames, a line monitor decodes
// UART_TX and checks each frame. Honours UART_TX_PARITY_EN when defined.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int OS    = 16;
   localparam int NBITS = 1 + 8 + P + 1;
   localparam int FLEN  = NBITS * OS;

   logic       sampleclk = 1'b0;
   logic       reset     = 1'b0;
   logic [7:0] TX_DATA   = 8'h00;
   logic       TX_EN     = 1'b0;
   logic       TX_STATUS;
   logic       TX_BUSY;
   logic       UART_TX;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] data;
      logic       par;
      bit         b2b;
   } exp_t;
   exp_t sb_q[$];

   uart_transmitter dut (
      .sampleclk (sampleclk),
      .reset     (reset),
      .TX_DATA   (TX_DATA),
      .TX_EN     (TX_EN),
      .TX_STATUS (TX_STATUS),
      .TX_BUSY   (TX_BUSY),
      .UART_TX   (UART_TX)
   );

   always #5 sampleclk = ~sampleclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Line monitor: samples every negedge, decodes one frame, compares against the scoreboard.
   bit         mon_act = 1'b0;
   bit         frame_ok;
   int         idx;
   int         gap = 1000;
   int         start_gap;
   logic       cur;
   logic       rx_par;
   logic [7:0] rx;

   always @(negedge sampleclk) begin
      int b;
      int s;
      exp_t e;
      if (!reset) begin
         mon_act = 1'b0;
         gap     = 1000;
      end else begin
         if (!mon_act) begin
            if (UART_TX == 1'b0) begin
               mon_act   = 1'b1;
               idx       = 0;
               frame_ok  = 1'b1;
               start_gap = gap;
            end else begin
               gap++;
            end
         end
         if (mon_act) begin
            b = idx / OS;
            s = idx % OS;
            if (s == 0) begin
               cur = UART_TX;
               if (b == 0 && cur !== 1'b0) frame_ok = 1'b0;
               if (b >= 1 && b <= 8) rx[b-1] = cur;
               if (P == 1 && b == 9) rx_par = cur;
               if (b >= 9 + P && cur !== 1'b1) frame_ok = 1'b0;
            end else if (UART_TX !== cur) begin
               frame_ok = 1'b0;
            end
            idx++;
            if (idx == FLEN) begin
               mon_act = 1'b0;
               gap     = 0;
               if (sb_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_frame: got %0h expected none", rx);
               end else begin
                  e = sb_q.pop_front();
                  check("frame_data", 32'(rx), 32'(e.data));
                  check("frame_shape", 32'(frame_ok), 32'd1);
                  if (P == 1) check("frame_parity", 32'(rx_par), 32'(e.par));
                  if (e.b2b) check("b2b_gap", 32'(start_gap), 32'd0);
               end
            end
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic p, input bit b2b);
      int n = 0;
      while (TX_STATUS !== 1'b1 && n < 400) begin
         @(negedge sampleclk);
         n++;
      end
      if (TX_STATUS !== 1'b1) begin
         check("send_wait", 32'(TX_STATUS), 32'd1);
      end else begin
         TX_DATA = d;
         TX_EN   = 1'b1;
         sb_q.push_back('{data: d, par: p, b2b: b2b});
         @(negedge sampleclk);
         TX_EN   = 1'b0;
         TX_DATA = ~d;
      end
   endtask

   task automatic drain(input int bound);
      int n = 0;
      while ((sb_q.size() != 0 || TX_BUSY !== 1'b0) && n < bound) begin
         @(negedge sampleclk);
         n++;
      end
      check("drain_queue", 32'(sb_q.size()), 32'd0);
      check("drain_idle", 32'(TX_BUSY), 32'd0);
   endtask

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: simulation exceeded its cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      // Reset state
      repeat (3) @(negedge sampleclk);
      check("rst_tx", 32'(UART_TX), 32'd1);
      check("rst_status", 32'(TX_STATUS), 32'd1);
      check("rst_busy", 32'(TX_BUSY), 32'd0);
      @(posedge sampleclk);
      #2 reset = 1'b1;
      repeat (2) @(negedge sampleclk);

      // 1: A5 frame, accept/start latency and busy width
      TX_DATA = 8'hA5;
      TX_EN   = 1'b1;
      sb_q.push_back('{data: 8'hA5, par: 1'b0, b2b: 1'b0});
      @(negedge sampleclk);
      TX_EN   = 1'b0;
      TX_DATA = 8'h00;
      check("lat_edge_n", 32'(UART_TX), 32'd1);
      check("status_after_accept", 32'(TX_STATUS), 32'd0);
      @(negedge sampleclk);
      check("lat_edge_n1", 32'(UART_TX), 32'd1);
      check("status_freed", 32'(TX_STATUS), 32'd1);
      @(negedge sampleclk);
      check("lat_edge_n2", 32'(UART_TX), 32'd0);
      cnt = 0;
      while (TX_BUSY === 1'b1 && cnt < 400) begin
         cnt++;
         @(negedge sampleclk);
      end
      check("busy_width", 32'(cnt), 32'(FLEN));
      drain(500);

      // 2: back-to-back 00 then FF
      send(8'h00, 1'b0, 1'b0);
      send(8'hFF, 1'b0, 1'b1);
      drain(1000);

      // 3: request while holding register full is dropped
      send(8'h11, 1'b0, 1'b0);
      send(8'h22, 1'b0, 1'b1);
      check("status_full", 32'(TX_STATUS), 32'd0);
      TX_DATA = 8'h3C;
      TX_EN   = 1'b1;
      @(negedge sampleclk);
      TX_EN   = 1'b0;
      drain(1000);

      // 4: abort in data bit 4, then a clean 55 frame
      send(8'hC3, 1'b0, 1'b0);
      repeat (88) @(negedge sampleclk);
      check("pre_abort_busy", 32'(TX_BUSY), 32'd1);
      reset = 1'b0;
      #1;
      check("abort_tx", 32'(UART_TX), 32'd1);
      check("abort_status", 32'(TX_STATUS), 32'd1);
      check("abort_busy", 32'(TX_BUSY), 32'd0);
      sb_q.delete();
      repeat (2) @(posedge sampleclk);
      #2 reset = 1'b1;
      @(negedge sampleclk);
      send(8'h55, 1'b0, 1'b0);
      drain(500);

      // 5: parity bit values
      if (P == 1) begin
         send(8'h07, 1'b1, 1'b0);
         send(8'h03, 1'b0, 1'b1);
         drain(1000);
      end

      // 6: all byte values, back-to-back
      for (int i = 0; i < 256; i++) begin
         send(8'(i), ^(8'(i)), i != 0);
      end
      drain(256 * 250);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
